// File: rtl/mac_accumulator.sv
// mac_accumulator: valid/ready multiply-accumulate stage that sums len products into a wide accumulator.
// Optional feature: define MAC_ACC_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module mac_accumulator #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W:0]     sum_w;
    logic [LEN_W-1:0]   cnt_inc;
    logic               carry;
    logic [ACC_W-1:0]   acc_next;

    // One-bit-wider adder exposes the carry out of the accumulator MSB.
    always_comb begin
        sum_w   = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
        carry   = sum_w[ACC_W];
        cnt_inc = cnt_q + {{(LEN_W - 1){1'b0}}, 1'b1};
`ifdef MAC_ACC_SAT_EN
        acc_next = (carry || ovf_q) ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
`else
        acc_next = sum_w[ACC_W-1:0];
`endif
    end

    // Next-state and datapath updates for the IDLE/ACC/HOLD controller.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = len;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (len == '0) ? HOLD : ACC;
                end
            end
            ACC: begin
                if (in_valid) begin
                    acc_d   = acc_next;
                    cnt_d   = cnt_inc;
                    ovf_d   = ovf_q | carry;
                    state_d = (cnt_inc == len_q) ? HOLD : ACC;
                end
            end
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset discards any partial job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    // Moore outputs decoded only from registered state.
    always_comb begin
        busy      = (state_q != IDLE);
        in_ready  = (state_q == ACC);
        out_valid = (state_q == HOLD);
        out_sum   = acc_q;
        out_ovf   = ovf_q;
    end

endmodule
